// File: rtl/minimac_rxpacker.sv
// minimac_rxpacker: pops bytes and EOF markers from the minimac receive FIFO,
// packs them little-endian into 32-bit words and writes them to the receive
// buffer RAM, then reports frame completion, byte count and error status.
// Frames that arrive with no buffer armed, or that run past MAX_BYTES, are
// drained from the FIFO and flagged.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   fifo_empty/ack/eof/data  first-word-fall-through FIFO read side
//   slot_arm              pulse: host has provided an empty buffer
//   mem_adr/dat/we        buffer RAM write port (word addressed)
//   rx_busy               a frame is being stored
//   rx_count              byte count of the last completed armed frame
//   rx_done/error/dropped one-cycle per-frame status pulses
module minimac_rxpacker #(
   parameter int ADDR_WIDTH = 9,
   parameter int MAX_BYTES  = 1536
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  fifo_empty,
   output logic                  fifo_ack,
   input  logic                  fifo_eof,
   input  logic [7:0]            fifo_data,
   input  logic                  slot_arm,
   output logic [ADDR_WIDTH-1:0] mem_adr,
   output logic [31:0]           mem_dat,
   output logic                  mem_we,
   output logic                  rx_busy,
   output logic [ADDR_WIDTH+1:0] rx_count,
   output logic                  rx_done,
   output logic                  rx_error,
   output logic                  rx_dropped
);

   localparam int CW = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RECV, DISCARD, FINISH} state_t;

   state_t        state, state_next;
   logic [CW-1:0] count;
   logic [31:0]   pack;
   logic [31:0]   pack_next;
   logic          armed;
   logic          err;
   logic          drop;
   logic [1:0]    lane;
   logic          at_max;

   assign lane   = count[1:0];
   assign at_max = (count == CW'(MAX_BYTES));

   // Lane 0 starts a fresh word, so the upper lanes of a partial final word
   // are always zero without an explicit clear after each write.
   always_comb begin
      pack_next = (lane == 2'd0) ? 32'h0 : pack;
      pack_next[{lane, 3'b000} +: 8] = fifo_data;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      fifo_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = armed ? RECV : DISCARD;
         end
         RECV: begin
            fifo_ack = !fifo_empty;
            if (!fifo_empty) begin
               if (fifo_eof)    state_next = FINISH;
               else if (at_max) state_next = DISCARD;
            end
         end
         DISCARD: begin
            fifo_ack = !fifo_empty;
            if (!fifo_empty && fifo_eof) state_next = FINISH;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         armed      <= 1'b0;
         count      <= '0;
         pack       <= '0;
         err        <= 1'b0;
         drop       <= 1'b0;
         mem_we     <= 1'b0;
         mem_adr    <= '0;
         mem_dat    <= '0;
         rx_busy    <= 1'b0;
         rx_count   <= '0;
         rx_done    <= 1'b0;
         rx_error   <= 1'b0;
         rx_dropped <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         rx_done    <= 1'b0;
         rx_error   <= 1'b0;
         rx_dropped <= 1'b0;

         // A fresh arm wins over the clear on FINISH entry so that a buffer
         // supplied while an unarmed frame is being drained is not lost.
         if (slot_arm && state != RECV)
            armed <= 1'b1;
         else if (state != FINISH && state_next == FINISH)
            armed <= 1'b0;

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (armed) begin
                     count   <= '0;
                     pack    <= '0;
                     err     <= 1'b0;
                     drop    <= 1'b0;
                     rx_busy <= 1'b1;
                  end else begin
                     drop    <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (fifo_ack) begin
                  if (!fifo_eof) begin
                     if (at_max) begin
                        err <= 1'b1;
                     end else begin
                        pack  <= pack_next;
                        count <= count + CW'(1);
                        if (lane == 2'd3) begin
                           mem_we  <= 1'b1;
                           mem_adr <= count[CW-1:2];
                           mem_dat <= pack_next;
                        end
                     end
                  end else begin
                     if (lane != 2'd0) begin
                        mem_we  <= 1'b1;
                        mem_adr <= count[CW-1:2];
                        mem_dat <= pack;
                     end
                     err <= fifo_data[0] | (count == '0);
                  end
               end
            end
            FINISH: begin
               if (drop) begin
                  rx_dropped <= 1'b1;
               end else begin
                  rx_count <= count;
                  rx_done  <= !err;
                  rx_error <= err;
               end
               rx_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_minimac_rxpacker.sv
module tb_minimac_rxpacker;
   localparam int AW = 9;
   localparam int MB = 1536;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          fifo_empty, fifo_ack, fifo_eof;
   logic [7:0]    fifo_data;
   logic          slot_arm = 1'b0;
   logic [AW-1:0] mem_adr;
   logic [31:0]   mem_dat;
   logic          mem_we, rx_busy, rx_done, rx_error, rx_dropped;
   logic [AW+1:0] rx_count;

   minimac_rxpacker #(.ADDR_WIDTH(AW), .MAX_BYTES(MB)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .fifo_empty(fifo_empty), .fifo_ack(fifo_ack), .fifo_eof(fifo_eof), .fifo_data(fifo_data),
      .slot_arm(slot_arm),
      .mem_adr(mem_adr), .mem_dat(mem_dat), .mem_we(mem_we),
      .rx_busy(rx_busy), .rx_count(rx_count),
      .rx_done(rx_done), .rx_error(rx_error), .rx_dropped(rx_dropped)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {logic [AW-1:0] adr; logic [31:0] dat;} wr_t;
   typedef struct packed {logic done; logic error; logic dropped; logic [AW+1:0] count;} ev_t;

   logic [8:0] fq[$];   // {eof, data}
   wr_t        wq[$];
   ev_t        eq[$];
   int         checks = 0, errors = 0, ack_cnt = 0;
   logic       ack_seen = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function void refresh();
      fifo_empty = (fq.size() == 0);
      {fifo_eof, fifo_data} = fifo_empty ? 9'h0 : fq[0];
   endfunction

   // FIFO model: pop after each cycle in which the DUT acked.
   always @(negedge sys_clk) ack_seen = fifo_ack;
   always @(posedge sys_clk) begin
      #1;
      if (ack_seen && fq.size() != 0) void'(fq.pop_front());
      refresh();
   end

   // Scoreboard monitor.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (fifo_ack) ack_cnt++;
         if (mem_we) begin
            checks++;
            assert (wq.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_write: observed adr=%0h dat=%0h expected no write", mem_adr, mem_dat);
            end
            if (wq.size() != 0) begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_adr", 64'(mem_adr), 64'(e.adr));
               chk("wr_dat", 64'(mem_dat), 64'(e.dat));
            end
         end
         if (rx_done | rx_error | rx_dropped) begin
            checks++;
            assert (eq.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_status: observed done=%0b err=%0b drop=%0b expected none",
                      rx_done, rx_error, rx_dropped);
            end
            if (eq.size() != 0) begin
               ev_t e;
               e = eq.pop_front();
               chk("status_flags", 64'({rx_done, rx_error, rx_dropped}), 64'({e.done, e.error, e.dropped}));
               chk("status_count", 64'(rx_count), 64'(e.count));
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      fq.push_back({1'b0, b});
      refresh();
   endtask

   task automatic push_eof(input logic [7:0] s);
      fq.push_back({1'b1, s});
      refresh();
   endtask

   task automatic arm();
      @(posedge sys_clk); #2 slot_arm = 1'b1;
      @(posedge sys_clk); #2 slot_arm = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((eq.size() != 0 || fq.size() != 0) && n < 5000) begin
         @(posedge sys_clk);
         n++;
      end
      repeat (4) @(posedge sys_clk);
      #2;
      checks++;
      assert (n < 5000) else begin
         errors++;
         $error("FAIL %s_timeout: observed %0d pending events expected 0", tag, eq.size());
      end
      chk({tag, "_pending_writes"}, 64'(wq.size()), 64'd0);
      chk({tag, "_busy_after"}, 64'(rx_busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},  64'(fifo_ack), 64'd0);
      chk({tag, "_we"},   64'(mem_we), 64'd0);
      chk({tag, "_adr"},  64'(mem_adr), 64'd0);
      chk({tag, "_dat"},  64'(mem_dat), 64'd0);
      chk({tag, "_busy"}, 64'(rx_busy), 64'd0);
      chk({tag, "_cnt"},  64'(rx_count), 64'd0);
      chk({tag, "_pulses"}, 64'({rx_done, rx_error, rx_dropped}), 64'd0);
   endtask

   initial begin
      refresh();
      // Reset state
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk_all_zero("reset");
      @(posedge sys_clk); #2 sys_rst = 1'b0;

      // 5-byte good frame
      arm();
      wq.push_back('{adr: 0, dat: 32'h44332211});
      wq.push_back('{adr: 1, dat: 32'h00000055});
      eq.push_back('{done: 1, error: 0, dropped: 0, count: 5});
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
      push_eof(8'h00);
      wait_idle("good5");
      chk("good5_count", 64'(rx_count), 64'd5);

      // Unarmed 8-byte frame is dropped
      ack_cnt = 0;
      eq.push_back('{done: 0, error: 0, dropped: 1, count: 5});
      for (int i = 0; i < 8; i++) push_byte(8'(8'hA0 + i));
      push_eof(8'h00);
      wait_idle("drop8");
      chk("drop8_acks", 64'(ack_cnt), 64'd9);
      chk("drop8_count_hold", 64'(rx_count), 64'd5);

      // PHY error on a 4-byte frame
      arm();
      wq.push_back('{adr: 0, dat: 32'hDDCCBBAA});
      eq.push_back('{done: 0, error: 1, dropped: 0, count: 4});
      push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
      push_eof(8'h01);
      wait_idle("phyerr");
      chk("phyerr_count", 64'(rx_count), 64'd4);
      // armed was cleared: the next frame is dropped
      eq.push_back('{done: 0, error: 0, dropped: 1, count: 4});
      push_byte(8'h01); push_byte(8'h02); push_eof(8'h00);
      wait_idle("disarmed");

      // Oversize frame: MAX_BYTES+3 bytes
      arm();
      for (int k = 0; k < MB / 4; k++)
         wq.push_back('{adr: AW'(k), dat: {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}});
      eq.push_back('{done: 0, error: 1, dropped: 0, count: (AW+2)'(MB)});
      for (int i = 0; i < MB + 3; i++) push_byte(8'(i));
      push_eof(8'h00);
      wait_idle("oversize");
      chk("oversize_count", 64'(rx_count), 64'(MB));

      // Zero-length frame
      arm();
      eq.push_back('{done: 0, error: 1, dropped: 0, count: 0});
      push_eof(8'h00);
      wait_idle("empty");
      chk("empty_count", 64'(rx_count), 64'd0);

      // Reset mid-frame
      arm();
      wq.push_back('{adr: 0, dat: 32'h04030201});
      for (int i = 1; i <= 6; i++) push_byte(8'(i));
      begin
         int n;
         n = 0;
         while (fq.size() != 0 && n < 100) begin @(posedge sys_clk); n++; end
      end
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("midframe_busy", 64'(rx_busy), 64'd1);
      chk("midframe_writes_done", 64'(wq.size()), 64'd0);
      @(posedge sys_clk); #2 sys_rst = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk_all_zero("midreset");
      @(posedge sys_clk); #2 sys_rst = 1'b0;
      eq.push_back('{done: 0, error: 0, dropped: 1, count: 0});
      for (int i = 7; i <= 10; i++) push_byte(8'(i));
      push_eof(8'h00);
      wait_idle("tail");
      arm();
      wq.push_back('{adr: 0, dat: 32'h14131211});
      eq.push_back('{done: 1, error: 0, dropped: 0, count: 4});
      push_byte(8'h11); push_byte(8'h12); push_byte(8'h13); push_byte(8'h14);
      push_eof(8'h00);
      wait_idle("rearm");
      chk("rearm_count", 64'(rx_count), 64'd4);

      // Back-to-back frames: armed one then unarmed one, nothing lost
      arm();
      ack_cnt = 0;
      wq.push_back('{adr: 0, dat: 32'h24232221});
      eq.push_back('{done: 1, error: 0, dropped: 0, count: 4});
      eq.push_back('{done: 0, error: 0, dropped: 1, count: 4});
      push_byte(8'h21); push_byte(8'h22); push_byte(8'h23); push_byte(8'h24); push_eof(8'h00);
      push_byte(8'h31); push_byte(8'h32); push_eof(8'h00);
      wait_idle("b2b");
      chk("b2b_acks", 64'(ack_cnt), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
